dual_port_bram_pipelined: RTL

Parametrised true dual-port block RAM with independent port widths, selectable read-during-write behaviour, and configurable read latency (1 or 2 cycles). After reset it runs a hardware clear sequence that zeroes the whole array. It flags out-of-range accesses and same-cycle write collisions. It is the general storage primitive for the weight, activation and line buffers of the inference datapath.

---
 rtl/dual_port_bram_pkg.sv | 21 ++
 rtl/bram_clear_fsm.sv | 43 ++++
 rtl/dual_port_bram_pipelined.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_bram_pkg.sv
// Shared types and helpers for the dual-port block RAM.
package dual_port_bram_pkg;

  typedef enum logic [1:0] {
    RDW_WRITE_FIRST,
    RDW_READ_FIRST,
    RDW_NO_CHANGE
  } rdw_mode_e;

  typedef enum logic {
    CLEAR,
    READY
  } bram_state_e;

  // Inclusive bit ranges [a_lo,a_hi] and [b_lo,b_hi] share at least one bit.
  function automatic logic overlaps(input int unsigned a_lo, input int unsigned a_hi,
                                    input int unsigned b_lo, input int unsigned b_hi);
    return (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

endpackage

// File: rtl/bram_clear_fsm.sv
// Post-reset clear sequencer: walks every storage word once, then hands the array to the ports.
module bram_clear_fsm
  import dual_port_bram_pkg::*;
#(
  parameter int unsigned Words        = 8,
  parameter bit          ClearOnReset = 1'b1,
  localparam int unsigned CntW        = (Words > 1) ? $clog2(Words) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            busy_o,
  output logic            clr_we_o,
  output logic [CntW-1:0] clr_addr_o
);

  bram_state_e     state_q;
  logic            busy_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      if (ClearOnReset) begin
        state_q <= CLEAR;
        busy_q  <= 1'b1;
      end else begin
        state_q <= READY;
        busy_q  <= 1'b0;
      end
    end else if (state_q == CLEAR) begin
      cnt_q <= cnt_q + CntW'(1);
      if (cnt_q == CntW'(Words - 1)) begin
        state_q <= READY;
        busy_q  <= 1'b0;
      end
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = busy_q;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/dual_port_bram_pipelined.sv
// True dual-port RAM with independent port widths, selectable read-during-write,
// 1- or 2-cycle read latency, range/collision flags and a zeroing pass after reset.
module dual_port_bram_pipelined
  import dual_port_bram_pkg::*;
#(
  parameter int unsigned ADataWidth   = 8,
  parameter int unsigned BDataWidth   = 8,
  parameter int unsigned BitDepth     = 8192,
  parameter int unsigned ReadLatency  = 1,
  parameter rdw_mode_e   RdwMode      = RDW_WRITE_FIRST,
  parameter bit          ClearOnReset = 1'b1,
  localparam int unsigned AAddrSize   = $clog2(BitDepth / ADataWidth + 1),
  localparam int unsigned BAddrSize   = $clog2(BitDepth / BDataWidth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_en_i,
  input  logic                  a_write_en_i,
  input  logic [AAddrSize-1:0]  a_addr_i,
  input  logic [ADataWidth-1:0] a_data_i,
  output logic [ADataWidth-1:0] a_data_o,
  output logic                  a_oob_o,
  input  logic                  b_en_i,
  input  logic                  b_write_en_i,
  input  logic [BAddrSize-1:0]  b_addr_i,
  input  logic [BDataWidth-1:0] b_data_i,
  output logic [BDataWidth-1:0] b_data_o,
  output logic                  b_oob_o,
  output logic                  busy_o,
  output logic                  collision_o
);

  localparam int unsigned MaxW   = (ADataWidth > BDataWidth) ? ADataWidth : BDataWidth;
  localparam int unsigned MinW   = (ADataWidth > BDataWidth) ? BDataWidth : ADataWidth;
  localparam int unsigned Ratio  = MaxW / MinW;
  localparam int unsigned Words  = BitDepth / MaxW;
  localparam int unsigned WordW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned ARatio = MaxW / ADataWidth;
  localparam int unsigned BRatio = MaxW / BDataWidth;
  localparam int unsigned ALaneW = (ARatio > 1) ? $clog2(ARatio) : 1;
  localparam int unsigned BLaneW = (BRatio > 1) ? $clog2(BRatio) : 1;
  localparam int unsigned ADepth = BitDepth / ADataWidth;
  localparam int unsigned BDepth = BitDepth / BDataWidth;

  if ((MaxW % MinW != 0) || ((Ratio & (Ratio - 1)) != 0)) begin : g_bad_ratio
    $error("port width ratio must be a power of 2");
  end
  if (BitDepth % MaxW != 0) begin : g_bad_depth
    $error("BitDepth must be a multiple of the wider port width");
  end
  if (!(ReadLatency == 1 || ReadLatency == 2)) begin : g_bad_lat
    $error("ReadLatency must be 1 or 2");
  end

  logic [MaxW-1:0]  mem [Words];
  logic             busy, clr_we;
  logic [WordW-1:0] clr_addr;

  bram_clear_fsm #(
    .Words        (Words),
    .ClearOnReset (ClearOnReset)
  ) u_clear (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  logic                  a_acc, a_oob, a_wr_req, a_wr;
  logic [WordW-1:0]      a_word;
  logic [ALaneW-1:0]     a_lane;
  logic [ADataWidth-1:0] a_old;
  int unsigned           a_lo, a_hi;
  logic                  b_acc, b_oob, b_wr_req, b_wr;
  logic [WordW-1:0]      b_word;
  logic [BLaneW-1:0]     b_lane;
  logic [BDataWidth-1:0] b_old;
  int unsigned           b_lo, b_hi;
  logic                  collide;

  assign a_acc    = a_en_i && !busy;
  assign a_oob    = 32'(a_addr_i) >= ADepth;
  assign a_word   = WordW'(32'(a_addr_i) / ARatio);
  assign a_lane   = ALaneW'(32'(a_addr_i) % ARatio);
  assign a_old    = mem[a_word][a_lane*ADataWidth +: ADataWidth];
  assign a_lo     = 32'(a_addr_i) * ADataWidth;
  assign a_hi     = a_lo + ADataWidth - 1;
  assign a_wr_req = a_acc && a_write_en_i && !a_oob;

  assign b_acc    = b_en_i && !busy;
  assign b_oob    = 32'(b_addr_i) >= BDepth;
  assign b_word   = WordW'(32'(b_addr_i) / BRatio);
  assign b_lane   = BLaneW'(32'(b_addr_i) % BRatio);
  assign b_old    = mem[b_word][b_lane*BDataWidth +: BDataWidth];
  assign b_lo     = 32'(b_addr_i) * BDataWidth;
  assign b_hi     = b_lo + BDataWidth - 1;
  assign b_wr_req = b_acc && b_write_en_i && !b_oob;

  // Port A has priority on overlapping writes; the losing B write behaves as a plain read.
  assign collide = a_wr_req && b_wr_req && overlaps(a_lo, a_hi, b_lo, b_hi);
  assign a_wr    = a_wr_req && !rst_i;
  assign b_wr    = b_wr_req && !collide && !rst_i;

  always_ff @(posedge clk_i) begin
    if (clr_we) mem[clr_addr] <= '0;
    if (b_wr)   mem[b_word][b_lane*BDataWidth +: BDataWidth] <= b_data_i;
    if (a_wr)   mem[a_word][a_lane*ADataWidth +: ADataWidth] <= a_data_i;
  end

  // ---- stage p1: read data selection and first register ----
  logic [ADataWidth-1:0] a_dat_p1_d, a_dat_p1_q;
  logic [BDataWidth-1:0] b_dat_p1_d, b_dat_p1_q;
  logic                  a_oob_p1_q, b_oob_p1_q, coll_q;

  always_comb begin
    a_dat_p1_d = a_old;
    if (a_oob) begin
      a_dat_p1_d = '0;
    end else if (a_wr_req) begin
      case (RdwMode)
        RDW_WRITE_FIRST: a_dat_p1_d = a_data_i;
        RDW_READ_FIRST:  a_dat_p1_d = a_old;
        default:         a_dat_p1_d = a_dat_p1_q;
      endcase
    end
  end

  always_comb begin
    b_dat_p1_d = b_old;
    if (b_oob) begin
      b_dat_p1_d = '0;
    end else if (b_wr_req && !collide) begin
      case (RdwMode)
        RDW_WRITE_FIRST: b_dat_p1_d = b_data_i;
        RDW_READ_FIRST:  b_dat_p1_d = b_old;
        default:         b_dat_p1_d = b_dat_p1_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_dat_p1_q <= '0;
      a_oob_p1_q <= 1'b0;
      b_dat_p1_q <= '0;
      b_oob_p1_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      if (a_acc) begin
        a_dat_p1_q <= a_dat_p1_d;
        a_oob_p1_q <= a_oob;
      end
      if (b_acc) begin
        b_dat_p1_q <= b_dat_p1_d;
        b_oob_p1_q <= b_oob;
      end
      coll_q <= collide;
    end
  end

  assign busy_o      = busy;
  assign collision_o = coll_q;

  // ---- stage p2: optional output register ----
  if (ReadLatency == 2) begin : g_lat2
    logic [ADataWidth-1:0] a_dat_p2_q;
    logic [BDataWidth-1:0] b_dat_p2_q;
    logic                  a_oob_p2_q, b_oob_p2_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        a_dat_p2_q <= '0;
        a_oob_p2_q <= 1'b0;
        b_dat_p2_q <= '0;
        b_oob_p2_q <= 1'b0;
      end else begin
        if (a_acc) begin
          a_dat_p2_q <= a_dat_p1_q;
          a_oob_p2_q <= a_oob_p1_q;
        end
        if (b_acc) begin
          b_dat_p2_q <= b_dat_p1_q;
          b_oob_p2_q <= b_oob_p1_q;
        end
      end
    end

    assign a_data_o = a_dat_p2_q;
    assign a_oob_o  = a_oob_p2_q;
    assign b_data_o = b_dat_p2_q;
    assign b_oob_o  = b_oob_p2_q;
  end else begin : g_lat1
    assign a_data_o = a_dat_p1_q;
    assign a_oob_o  = a_oob_p1_q;
    assign b_data_o = b_dat_p1_q;
    assign b_oob_o  = b_oob_p1_q;
  end

endmodule
